hub75_capture: RTL and testbench

Receive-side model of the HUB75 panel bus driven by `hub75_output`. It oversamples the panel pins with the system clock, shifts RGB bits in on each `hub75_clk` rising edge, and on each `hub75_latch` rising edge presents the completed double row plus its `hub75_addr` on a valid/ready port. It is used for loopback self-test on the CMOD A7 and as a checker in simulation benches.

---
 rtl/hub75_capture_if.sv | 38 +++
 rtl/hub75_capture.sv | 172 +++++++++++++++++
 tb/tb_hub75_capture.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/hub75_capture_if.sv
`timescale 1ns/1ps
// Row-output port of hub75_capture: captured double row, status and valid/ready handshake.
// Carries row_oe_cycles when HUB75_CAPTURE_OE_EN is defined.
interface hub75_capture_if #(
  parameter int NUM_COLS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int CW        = $clog2(NUM_COLS + 1)
);
  logic [3*NUM_COLS-1:0]        row_rgb0;
  logic [3*NUM_COLS-1:0]        row_rgb1;
  logic [$clog2(SCAN_RATE)-1:0] row_addr;
  logic [CW-1:0]                row_count;
  logic                         row_long;
  logic                         row_valid;
  logic                         row_ready;
  logic                         overflow;
`ifdef HUB75_CAPTURE_OE_EN
  logic [15:0]                  row_oe_cycles;

  modport master (
    output row_rgb0, row_rgb1, row_addr, row_count, row_long, row_valid, overflow, row_oe_cycles,
    input  row_ready
  );
  modport slave (
    input  row_rgb0, row_rgb1, row_addr, row_count, row_long, row_valid, overflow, row_oe_cycles,
    output row_ready
  );
`else
  modport master (
    output row_rgb0, row_rgb1, row_addr, row_count, row_long, row_valid, overflow,
    input  row_ready
  );
  modport slave (
    input  row_rgb0, row_rgb1, row_addr, row_count, row_long, row_valid, overflow,
    output row_ready
  );
`endif
endinterface

// File: rtl/hub75_capture.sv
`timescale 1ns/1ps
// HUB75 receive-side capture: oversamples panel pins, shifts RGB on hub75_clk rises and
// presents each latched double row on a valid/ready port. Optional HUB75_CAPTURE_OE_EN adds row_oe_cycles.
module hub75_capture #(
  parameter int NUM_COLS  = 64,
  parameter int SCAN_RATE = 32,
  parameter int CW        = $clog2(NUM_COLS + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_in_n,
  input  logic                         hub75_clk,
  input  logic                         hub75_latch,
  input  logic                         hub75_OE,
  input  logic [$clog2(SCAN_RATE)-1:0] hub75_addr,
  input  logic [2:0]                   hub75_rgb0,
  input  logic [2:0]                   hub75_rgb1,
  hub75_capture_if.master              row_if
);
  localparam int AW = $clog2(SCAN_RATE);
  localparam int BW = 3 * NUM_COLS;
  localparam logic [CW-1:0] FULL = CW'(NUM_COLS);

  typedef enum logic {SHIFT, PEND} state_t;
  state_t state_reg, state_next;

  // Control pins packed as {oe, latch, clk}; the prev stage feeds edge detection.
  logic [2:0]    ctl_meta_reg, ctl_sync_reg, ctl_prev_reg;
  logic [AW-1:0] addr_meta_reg, addr_sync_reg;
  logic          clk_rise, latch_rise;
  logic          oe_prev_unused;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      ctl_meta_reg  <= '0;
      ctl_sync_reg  <= '0;
      ctl_prev_reg  <= '0;
      addr_meta_reg <= '0;
      addr_sync_reg <= '0;
    end else begin
      ctl_meta_reg  <= {hub75_OE, hub75_latch, hub75_clk};
      ctl_sync_reg  <= ctl_meta_reg;
      ctl_prev_reg  <= ctl_sync_reg;
      addr_meta_reg <= hub75_addr;
      addr_sync_reg <= addr_meta_reg;
    end
  end

  assign clk_rise       = ctl_sync_reg[0] & ~ctl_prev_reg[0];
  assign latch_rise     = ctl_sync_reg[1] & ~ctl_prev_reg[1];
  assign oe_prev_unused = ctl_prev_reg[2];

  logic [2:0]    rgb_pin    [2];
  logic [BW-1:0] shift_next [2];
  assign rgb_pin[0] = hub75_rgb0;
  assign rgb_pin[1] = hub75_rgb1;

  // Data pins see the same two-stage delay as the clock pin, keeping them aligned with clk_rise.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_half
      logic [2:0]    rgb_meta_reg, rgb_sync_reg;
      logic [BW-1:0] shift_reg;

      always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
          rgb_meta_reg <= '0;
          rgb_sync_reg <= '0;
          shift_reg    <= '0;
        end else begin
          rgb_meta_reg <= rgb_pin[gi];
          rgb_sync_reg <= rgb_meta_reg;
          shift_reg    <= shift_next[gi];
        end
      end

      assign shift_next[gi] = clk_rise ? {shift_reg[BW-4:0], rgb_sync_reg} : shift_reg;
    end
  endgenerate

  logic [CW-1:0] col_cnt_reg, col_cnt_next;
  logic          long_reg, long_next;

  always_comb begin
    col_cnt_next = col_cnt_reg;
    long_next    = long_reg;
    if (clk_rise) begin
      if (col_cnt_reg == FULL) long_next = 1'b1;
      else                     col_cnt_next = col_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      col_cnt_reg <= '0;
      long_reg    <= 1'b0;
    end else if (latch_rise) begin
      col_cnt_reg <= '0;
      long_reg    <= 1'b0;
    end else begin
      col_cnt_reg <= col_cnt_next;
      long_reg    <= long_next;
    end
  end

  logic load, accept, drop;

  always_comb begin
    state_next       = state_reg;
    row_if.row_valid = 1'b0;
    accept           = 1'b0;
    load             = 1'b0;
    drop             = 1'b0;
    case (state_reg)
      SHIFT: begin
        if (latch_rise) begin
          load       = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        row_if.row_valid = 1'b1;
        accept           = row_if.row_ready;
        // A latch in the same cycle as the accept refills the slot instead of overflowing.
        if (latch_rise) begin
          if (accept) load = 1'b1;
          else        drop = 1'b1;
        end
        if (load)        state_next = PEND;
        else if (accept) state_next = SHIFT;
      end
      default: state_next = SHIFT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_reg        <= SHIFT;
      row_if.row_rgb0  <= '0;
      row_if.row_rgb1  <= '0;
      row_if.row_addr  <= '0;
      row_if.row_count <= '0;
      row_if.row_long  <= 1'b0;
      row_if.overflow  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        row_if.row_rgb0  <= shift_next[0];
        row_if.row_rgb1  <= shift_next[1];
        row_if.row_addr  <= addr_sync_reg;
        row_if.row_count <= col_cnt_next;
        row_if.row_long  <= long_next;
      end
      if (drop) row_if.overflow <= 1'b1;
    end
  end

`ifdef HUB75_CAPTURE_OE_EN
  // Cycles with the panel lit (OE low) since the previous latch rise.
  logic [15:0] oe_cnt_reg;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      oe_cnt_reg           <= '0;
      row_if.row_oe_cycles <= '0;
    end else begin
      if (latch_rise)                                       oe_cnt_reg <= '0;
      else if (!ctl_sync_reg[2] && oe_cnt_reg != 16'hFFFF) oe_cnt_reg <= oe_cnt_reg + 16'd1;
      if (load) row_if.row_oe_cycles <= oe_cnt_reg;
    end
  end
`endif
endmodule

// File: tb/tb_hub75_capture.sv
`timescale 1ns/1ps
// Directed bench for hub75_capture: reset, full/short/long rows, backpressure, coincident clock+latch.
module tb_hub75_capture;
  localparam int NC = 64;
  localparam int SR = 32;
  localparam int BW = 3 * NC;
  localparam int AW = 5;

  logic          clk_in      = 1'b0;
  logic          rst_in_n    = 1'b0;
  logic          hub75_clk   = 1'b0;
  logic          hub75_latch = 1'b0;
  logic          hub75_OE    = 1'b1;
  logic [AW-1:0] hub75_addr  = '0;
  logic [2:0]    hub75_rgb0  = '0;
  logic [2:0]    hub75_rgb1  = '0;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] m0 = '0, m1 = '0, snap0, snap1;

  always #50 clk_in = ~clk_in;

  hub75_capture_if #(.NUM_COLS(NC), .SCAN_RATE(SR)) rif ();

  hub75_capture #(.NUM_COLS(NC), .SCAN_RATE(SR)) dut (
    .clk_in      (clk_in),
    .rst_in_n    (rst_in_n),
    .hub75_clk   (hub75_clk),
    .hub75_latch (hub75_latch),
    .hub75_OE    (hub75_OE),
    .hub75_addr  (hub75_addr),
    .hub75_rgb0  (hub75_rgb0),
    .hub75_rgb1  (hub75_rgb1),
    .row_if      (rif)
  );

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One pixel: data set, 2 cycles setup, clock high 2, low 2; the model tracks the panel shift.
  task automatic shift_px(input logic [2:0] r0, input logic [2:0] r1);
    @(negedge clk_in);
    hub75_rgb0 = r0;
    hub75_rgb1 = r1;
    m0 = {m0[BW-4:0], r0};
    m1 = {m1[BW-4:0], r1};
    repeat (2) @(negedge clk_in);
    hub75_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    hub75_clk = 1'b0;
  endtask

  task automatic latch_and_wait(input string tag, input bit with_clk);
    bit seen;
    seen = 1'b0;
    @(negedge clk_in);
    hub75_latch = 1'b1;
    if (with_clk) hub75_clk = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (i >= 2 && rif.row_valid) begin
        seen = 1'b1;
        break;
      end
    end
    hub75_latch = 1'b0;
    hub75_clk   = 1'b0;
    chk({tag, "_valid"}, seen, 1'b1);
  endtask

  task automatic check_row(input string tag, input int e_addr, input int e_cnt, input bit e_long,
                           input logic [BW-1:0] e0, input logic [BW-1:0] e1);
    $display("row %s: addr=%0d count=%0d long=%0b", tag, rif.row_addr, rif.row_count, rif.row_long);
    chk({tag, "_addr"},  rif.row_addr,  e_addr);
    chk({tag, "_count"}, rif.row_count, e_cnt);
    chk({tag, "_long"},  rif.row_long,  e_long);
    chk({tag, "_rgb0"},  rif.row_rgb0,  e0);
    chk({tag, "_rgb1"},  rif.row_rgb1,  e1);
  endtask

  task automatic consume(input string tag);
    @(negedge clk_in);
    rif.row_ready = 1'b1;
    @(negedge clk_in);
    rif.row_ready = 1'b0;
    chk({tag, "_drop"}, rif.row_valid, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rif.row_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in_n = 1'b1;
    @(negedge clk_in);
    chk("rst_valid",    rif.row_valid, 1'b0);
    chk("rst_overflow", rif.overflow,  1'b0);
    chk("rst_count",    rif.row_count, 0);
    chk("rst_rgb0",     rif.row_rgb0,  '0);

    // Reset in the middle of a row clears buffers and counter.
    hub75_addr = 5'd3;
    for (int i = 0; i < 10; i++) shift_px(3'd5, 3'd2);
    @(negedge clk_in);
    rst_in_n = 1'b0;
    m0 = '0;
    m1 = '0;
    hub75_addr = '0;
    repeat (2) @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk_in);
    latch_and_wait("rstrow", 1'b0);
    check_row("rstrow", 0, 0, 1'b0, '0, '0);
    consume("rstrow");

    // Full row with ready held high: exact valid latency.
    rif.row_ready = 1'b1;
    hub75_addr = 5'd5;
    for (int i = 0; i < NC; i++) shift_px(3'(i % 8), 3'(7 - i % 8));
    @(negedge clk_in);
    hub75_latch = 1'b1;
    @(negedge clk_in);
    chk("full_lat1", rif.row_valid, 1'b0);
    @(negedge clk_in);
    chk("full_lat2", rif.row_valid, 1'b0);
    @(negedge clk_in);
    chk("full_lat3", rif.row_valid, 1'b1);
    check_row("full", 5, 64, 1'b0, m0, m1);
    chk("full_px63_rgb0", rif.row_rgb0[BW-1 -: 3], 3'd0);
    chk("full_px0_rgb0",  rif.row_rgb0[2:0],       3'd7);
    hub75_latch = 1'b0;
    @(negedge clk_in);
    chk("full_handshake_drop", rif.row_valid, 1'b0);
    rif.row_ready = 1'b0;

    // Short row, then a long row that saturates the count.
    hub75_addr = 5'd9;
    for (int i = 0; i < 10; i++) shift_px(3'(i % 8), 3'(7 - i % 8));
    latch_and_wait("short", 1'b0);
    check_row("short", 9, 10, 1'b0, m0, m1);
    consume("short");

    hub75_addr = 5'd31;
    for (int i = 0; i < 70; i++) shift_px(3'(i % 8), 3'((3 * i) % 8));
    latch_and_wait("long", 1'b0);
    check_row("long", 31, 64, 1'b1, m0, m1);
    chk("long_px0_rgb0", rif.row_rgb0[2:0], 3'd5);
    consume("long");

    // Backpressure: second latch while the first row is pending is dropped.
    hub75_addr = 5'd2;
    for (int i = 0; i < 4; i++) shift_px(3'd1, 3'd6);
    latch_and_wait("bpA", 1'b0);
    snap0 = m0;
    snap1 = m1;
    chk("bpA_overflow", rif.overflow, 1'b0);
    hub75_addr = 5'd7;
    for (int i = 0; i < 6; i++) shift_px(3'd4, 3'd3);
    @(negedge clk_in);
    hub75_latch = 1'b1;
    repeat (4) @(negedge clk_in);
    hub75_latch = 1'b0;
    repeat (2) @(negedge clk_in);
    chk("bpB_overflow", rif.overflow, 1'b1);
    chk("bpB_valid", rif.row_valid, 1'b1);
    check_row("bpB_held", 2, 4, 1'b0, snap0, snap1);
    consume("bp");
    chk("bp_overflow_sticky", rif.overflow, 1'b1);

    // 64th clock rise coincides with the latch rise.
    hub75_addr = 5'd1;
    for (int i = 0; i < NC - 1; i++) shift_px(3'(i % 8), 3'((i + 1) % 8));
    @(negedge clk_in);
    hub75_rgb0 = 3'd6;
    hub75_rgb1 = 3'd1;
    m0 = {m0[BW-4:0], 3'd6};
    m1 = {m1[BW-4:0], 3'd1};
    repeat (2) @(negedge clk_in);
    latch_and_wait("simul", 1'b1);
    check_row("simul", 1, 64, 1'b0, m0, m1);
    chk("simul_px0_rgb0", rif.row_rgb0[2:0], 3'd6);
    consume("simul");

`ifdef HUB75_CAPTURE_OE_EN
    @(negedge clk_in);
    hub75_OE = 1'b0;
    repeat (100) @(negedge clk_in);
    hub75_OE = 1'b1;
    repeat (3) @(negedge clk_in);
    latch_and_wait("oe", 1'b0);
    chk("oe_cycles", rif.row_oe_cycles, 16'd100);
    consume("oe");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
